hazard_sequencer: RTL

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It decides each cycle whether PC and IF/ID advance, whether IF/ID is flushed, and whether the ID/EX register captures real control bits or a bubble. Load-use interlocks, taken-branch/jump flushes and external freeze requests (e.g. memory busy) are all arbitrated here. Saturating stall and flush statistics counters are included.

---
 rtl/hazard_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall sequencer: arbitrates load-use interlocks, taken
// branch/jump flushes and external freezes for the 5-stage core, and keeps
// saturating stall/flush statistics.
module hazard_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             freeze_req,
    input  logic             stat_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_ctrl_en,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned REM_W = 3;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             lu_hazard_c;

    // Load in EX writes a register the ID instruction is about to read.
    assign lu_hazard_c = ex_mem_read && (ex_rt != 5'd0) &&
                         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // State and remaining-flush registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Next state and Mealy pipeline-control outputs.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_ctrl_en = 1'b1;
        busy         = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (freeze_req) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_ctrl_en = 1'b0;
                    state_d      = ST_FREEZE;
                end else if (lu_hazard_c) begin
                    // Single bubble; branch outcome is unreliable this cycle.
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_ctrl_en = 1'b0;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        rem_d   = REM_W'(FLUSH_CYCLES - 1);
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FREEZE: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_ctrl_en = 1'b0;
                busy         = 1'b1;
                if (!freeze_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (freeze_req) begin
                    // Freeze wins; any remaining squash cycles are dropped.
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_ctrl_en = 1'b0;
                    state_d      = ST_FREEZE;
                end else begin
                    ifid_flush = 1'b1;
                    rem_d      = rem_q - REM_W'(1);
                    if (rem_q == REM_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_ctrl_en = 1'b0;
            busy         = 1'b0;
        end
    end

    // Saturating statistics counters; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (stat_clr) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (ifid_flush && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
